// File: rtl/seller_pkg.sv
// Shared types and constants for the LED selector / credit controller.
// Holds the state enum, sel_n bit positions and the credit ceiling.
package seller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_REFUND   = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;

    localparam int SEL_IDLE  = 6;
    localparam int SEL_LED1  = 5;
    localparam int SEL_LED2  = 4;
    localparam int SEL_LED3  = 3;
    localparam int SEL_LED4  = 2;
    localparam int SEL_FLASH = 1;
    localparam int SEL_PULSE = 0;

    localparam logic [2:0] MAX_CREDIT = 3'd4;

    // Active-low one-cold pattern select for a given state and credit.
    function automatic logic [6:0] sel_decode(input state_e st, input logic [2:0] cr);
        logic [6:0] sel;
        sel = 7'h7F;
        case (st)
            ST_CREDIT: begin
                case (cr)
                    3'd1:    sel[SEL_LED1] = 1'b0;
                    3'd2:    sel[SEL_LED2] = 1'b0;
                    3'd3:    sel[SEL_LED3] = 1'b0;
                    3'd4:    sel[SEL_LED4] = 1'b0;
                    default: sel[SEL_IDLE] = 1'b0;
                endcase
            end
            ST_DISPENSE:         sel[SEL_FLASH] = 1'b0;
            ST_REFUND, ST_ERROR: sel[SEL_PULSE] = 1'b0;
            default:             sel[SEL_IDLE]  = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_sel_ctrl_hold_timer.sv
// hold_timer: loadable down-counter; expire_o is high for the single cycle
// in which the count is 1, so a load of N gives exactly N cycles.
module hold_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == ONE);

endmodule

// File: rtl/led_sel_ctrl.sv
// Credit / vend controller driving the active-low LED pattern selects.
// Define LED_SEL_TIMEOUT_EN to add the CREDIT inactivity auto-refund.
module led_sel_ctrl
    import seller_pkg::*;
#(
    parameter int PRICE          = 3,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic       buy,
    input  logic       cancel,
    output logic [6:0] sel_n,
    output logic [2:0] credit,
    output logic       vend,
    output logic       refund_valid,
    output logic [2:0] refund_units,
    output logic       coin_reject
);

    if (PRICE < 1 || PRICE > 4) begin : g_bad_price
        $error("PRICE must be in 1..4");
    end
    if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("HOLD_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    localparam logic [2:0]  PRICE_U  = 3'(PRICE);
    localparam logic [31:0] HOLD_VAL = 32'(HOLD_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] credit_q, credit_d;
    logic       vend_q, vend_d;
    logic       refund_valid_q, refund_valid_d;
    logic [2:0] refund_units_q, refund_units_d;
    logic       coin_reject_q, coin_reject_d;
    logic [6:0] sel_n_q;
    logic       hold_load, hold_expire, tmo_hit;

`ifdef LED_SEL_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        any_pulse;

    assign any_pulse = coin_in | buy | cancel;
    assign tmo_hit   = (state_q == ST_CREDIT) && !any_pulse && (tmo_q == TMO_LAST);

    // Counts only while staying in CREDIT with no pulse; entry and pulses clear it.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_CREDIT && state_d == ST_CREDIT && !any_pulse) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_d         = 1'b0;
        refund_valid_d = 1'b0;
        refund_units_d = '0;
        coin_reject_d  = 1'b0;
        hold_load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_in) begin
                    state_d  = ST_CREDIT;
                    credit_d = 3'd1;
                end
            end
            ST_CREDIT: begin
                if (cancel || tmo_hit) begin
                    refund_valid_d = 1'b1;
                    refund_units_d = credit_q;
                    credit_d       = '0;
                    coin_reject_d  = coin_in;
                    state_d        = ST_REFUND;
                    hold_load      = 1'b1;
                end else if (buy) begin
                    coin_reject_d = coin_in;
                    hold_load     = 1'b1;
                    if (credit_q >= PRICE_U) begin
                        credit_d = credit_q - PRICE_U;
                        vend_d   = 1'b1;
                        state_d  = ST_DISPENSE;
                    end else begin
                        state_d  = ST_ERROR;
                    end
                end else if (coin_in) begin
                    if (credit_q < MAX_CREDIT) begin
                        credit_d = credit_q + 3'd1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_in;
                if (hold_expire) begin
                    state_d = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
                end
            end
            ST_REFUND: begin
                coin_reject_d = coin_in;
                if (hold_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                coin_reject_d = coin_in;
                if (hold_expire) begin
                    state_d = ST_CREDIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            vend_q         <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_units_q <= '0;
            coin_reject_q  <= 1'b0;
            sel_n_q        <= sel_decode(ST_IDLE, 3'd0);
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_q         <= vend_d;
            refund_valid_q <= refund_valid_d;
            refund_units_q <= refund_units_d;
            coin_reject_q  <= coin_reject_d;
            // Decoded from the current registers, so the LEDs trail state by one cycle.
            sel_n_q        <= sel_decode(state_q, credit_q);
        end
    end

    hold_timer #(
        .WIDTH(32)
    ) u_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (hold_load),
        .load_val_i(HOLD_VAL),
        .expire_o  (hold_expire)
    );

    assign sel_n        = sel_n_q;
    assign credit       = credit_q;
    assign vend         = vend_q;
    assign refund_valid = refund_valid_q;
    assign refund_units = refund_units_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_led_sel_ctrl.sv
// Self-checking bench for led_sel_ctrl: directed scenarios followed by random
// pulses, every cycle compared against a behavioural model of the vending rules.
module tb_led_sel_ctrl;

    localparam int HOLD  = 8;
    localparam int TMO   = 32;
    localparam int PRICE = 3;
`ifdef LED_SEL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_CREDIT = 1, M_DISP = 2, M_REF = 3, M_ERR = 4;

    logic       clk = 1'b0;
    logic       rst, coin_in, buy, cancel;
    logic [6:0] sel_n;
    logic [2:0] credit;
    logic       vend, refund_valid, coin_reject;
    logic [2:0] refund_units;

    int checks = 0;
    int errors = 0;

    int         m_mode, m_credit, m_left, m_quiet, e_ru;
    logic [6:0] e_sel;
    logic       e_vend, e_rv, e_rej;

    always #5 clk = ~clk;

    led_sel_ctrl #(
        .PRICE(PRICE), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .buy(buy), .cancel(cancel),
        .sel_n(sel_n), .credit(credit), .vend(vend), .refund_valid(refund_valid),
        .refund_units(refund_units), .coin_reject(coin_reject)
    );

    // Expected LED pattern: one low bit, idle=6, led n = 6-n, flash=1, pulse=0.
    function automatic logic [6:0] pat(input int mode, input int cr);
        logic [6:0] one;
        int low;
        one = 7'd1;
        case (mode)
            M_IDLE:   low = 6;
            M_CREDIT: low = 6 - cr;
            M_DISP:   low = 1;
            default:  low = 0;
        endcase
        return ~(one << low);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_left = 0; m_quiet = 0;
        e_sel = pat(M_IDLE, 0); e_vend = 0; e_rv = 0; e_ru = 0; e_rej = 0;
    endtask

    task automatic enter_hold(input int mode);
        m_mode = mode;
        m_left = HOLD;
    endtask

    task automatic model_step(input bit c, input bit b, input bit x);
        bit timed_out;
        e_sel = pat(m_mode, m_credit);
        e_vend = 0; e_rv = 0; e_ru = 0; e_rej = 0;
        case (m_mode)
            M_IDLE: begin
                if (c) begin m_mode = M_CREDIT; m_credit = 1; m_quiet = 0; end
            end
            M_CREDIT: begin
                timed_out = 0;
                if (!(c || b || x)) begin
                    m_quiet++;
                    timed_out = TMO_EN && (m_quiet >= TMO);
                end else begin
                    m_quiet = 0;
                end
                if (x || timed_out) begin
                    e_rv = 1; e_ru = m_credit; m_credit = 0; e_rej = c;
                    enter_hold(M_REF);
                end else if (b) begin
                    e_rej = c;
                    if (m_credit >= PRICE) begin
                        m_credit -= PRICE; e_vend = 1; enter_hold(M_DISP);
                    end else begin
                        enter_hold(M_ERR);
                    end
                end else if (c) begin
                    if (m_credit == 4) e_rej = 1;
                    else m_credit++;
                end
            end
            default: begin
                e_rej = c;
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == M_REF)      m_mode = M_IDLE;
                    else if (m_mode == M_ERR) m_mode = M_CREDIT;
                    else                      m_mode = (m_credit > 0) ? M_CREDIT : M_IDLE;
                    m_quiet = 0;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("sel_n", 8'(sel_n), 8'(e_sel));
        chk("credit", 8'(credit), 8'(m_credit));
        chk("vend", 8'(vend), 8'(e_vend));
        chk("refund_valid", 8'(refund_valid), 8'(e_rv));
        chk("refund_units", 8'(refund_units), 8'(e_ru));
        chk("coin_reject", 8'(coin_reject), 8'(e_rej));
    endtask

    task automatic cycle(input bit c, input bit b, input bit x);
        @(negedge clk);
        coin_in = c; buy = b; cancel = x;
        @(posedge clk);
        model_step(c, b, x);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; coin_in = 1'b0; buy = 1'b0; cancel = 1'b0;
        model_reset();
        #2;
        check_model();
        chk("reset_sel", 8'(sel_n), 8'b0011_1111);
        @(negedge clk);
        rst = 1'b0;

        // Three coins: credit 1,2,3 with LEDs trailing by a cycle.
        cycle(1, 0, 0);
        chk("first_coin_credit", 8'(credit), 8'd1);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("three_coins_credit", 8'(credit), 8'd3);
        idle(1);
        chk("led3_sel", 8'(sel_n), 8'b0111_0111);

        // Credit 4 then buy: vend, credit 1, flash for HOLD cycles, then led1.
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("buy_vend", 8'(vend), 8'd1);
        chk("buy_credit", 8'(credit), 8'd1);
        idle(HOLD);
        chk("dispense_flash", 8'(sel_n), 8'b0111_1101);
        idle(1);
        chk("after_dispense_led1", 8'(sel_n), 8'b0101_1111);

        // Credit 2, buy with coin: error, coin rejected, credit kept.
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        chk("err_reject", 8'(coin_reject), 8'd1);
        chk("err_credit", 8'(credit), 8'd2);
        idle(HOLD);
        chk("error_pulse", 8'(sel_n), 8'b0111_1110);
        idle(1);
        chk("after_error_led2", 8'(sel_n), 8'b0110_1111);

        // Credit 4, extra coin rejected, then cancel refunds 4.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("full_reject", 8'(coin_reject), 8'd1);
        chk("full_credit", 8'(credit), 8'd4);
        cycle(0, 0, 1);
        chk("cancel_valid", 8'(refund_valid), 8'd1);
        chk("cancel_units", 8'(refund_units), 8'd4);
        idle(HOLD + 1);
        chk("after_refund_idle", 8'(sel_n), 8'b0011_1111);

        // Inactivity: auto-refund only when the timeout feature is built in.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        idle(TMO);
        chk("timeout_valid", 8'(refund_valid), TMO_EN ? 8'd1 : 8'd0);
        chk("timeout_units", 8'(refund_units), TMO_EN ? 8'd2 : 8'd0);
        idle(HOLD + 2);
        cycle(0, 0, 1);
        idle(HOLD + 1);

        // Reset in the middle of DISPENSE aborts at once.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        idle(2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("async_rst_sel", 8'(sel_n), 8'b0011_1111);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 0, 0);
        chk("post_reset_coin", 8'(credit), 8'd1);

        // Random pulses, dense then sparse so long quiet spells also occur.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
